// File: rtl/key_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_pkg
// Description : Shared types and constants for the key_debounce block.
//               - key_fsm_e : per-key debounce state encoding
//               - default timing constants for a 50 MHz system clock
//               - cnt_width : counter width needed to hold a maximum value
// Revision    : 1.0 - initial release
// ============================================================================
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } key_fsm_e;

    localparam int TICK_DIV_1MS_50MHZ   = 50_000;
    localparam int DB_TICKS_DEFAULT     = 20;
    localparam int REPEAT_DELAY_DEFAULT = 500;
    localparam int REPEAT_RATE_DEFAULT  = 100;

    // Bits needed to represent values 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage : key_debounce_pkg
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_ch
// Description : One push-button channel: 2-FF synchronizer, polarity
//               normalisation, 4-state debounce FSM with a saturating tick
//               counter, and registered level / event outputs.
//               Optional auto-repeat is built when KEY_DEBOUNCE_REPEAT_EN
//               is defined.
// Ports       : sys_clk     - system clock
//               sys_rst     - asynchronous active-high reset
//               key_i       - raw pin level (asynchronous)
//               tick_i      - shared debounce tick, one cycle wide
//               state_o     - debounced level, 1 = pressed
//               state_nxt_o - value state_o takes after the next edge
//               press_o     - one-cycle accepted-press (or repeat) pulse
//               release_o   - one-cycle accepted-release pulse
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int KEY_ACTIVE_LOW     = 1,
    parameter int DB_TICKS           = DB_TICKS_DEFAULT,
    parameter int REPEAT_DELAY_TICKS = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_RATE_TICKS  = REPEAT_RATE_DEFAULT
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_i,
    input  logic tick_i,
    output logic state_o,
    output logic state_nxt_o,
    output logic press_o,
    output logic release_o
);

    // Pin level seen while the button is not pressed.
    localparam logic c_pin_idle = (KEY_ACTIVE_LOW != 0);
    localparam int   DB_W       = cnt_width(DB_TICKS);
    localparam logic [DB_W-1:0] c_db_full = DB_W'(DB_TICKS);

    // Configuration sanity, evaluated at elaboration.
    if (DB_TICKS < 1) begin : g_chk_db
        $error("key_debounce_ch: DB_TICKS must be >= 1");
    end
    if (REPEAT_DELAY_TICKS < 1 || REPEAT_RATE_TICKS < 1) begin : g_chk_rep
        $error("key_debounce_ch: REPEAT_*_TICKS must be >= 1");
    end

    // ------------------------------------------------------------------
    // Synchronizer and normalisation
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       act;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_q <= {2{c_pin_idle}};
        end else begin
            sync_q <= {sync_q[0], key_i};
        end
    end

    // XOR with the idle level maps the pin to 1 = pressed for either polarity.
    assign act = sync_q[1] ^ c_pin_idle;

    // ------------------------------------------------------------------
    // Debounce counter helpers
    // ------------------------------------------------------------------
    key_fsm_e        fsm_q, fsm_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [DB_W-1:0] db_cnt_inc;
    logic            db_done;
    logic            state_q, state_d;
    logic            press_q, press_d;
    logic            release_q, release_d;

    // Saturating increment: the counter can hold DB_TICKS and never wraps.
    assign db_cnt_inc = (db_cnt_q == c_db_full) ? db_cnt_q : db_cnt_q + DB_W'(1);
    assign db_done    = (db_cnt_inc == c_db_full);

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ?
                             REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
    localparam int REP_W   = cnt_width(REP_MAX);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [REP_W-1:0] rep_cnt_inc;
    logic [REP_W-1:0] rep_limit;
    logic             rep_first_q, rep_first_d;
    logic             rep_hit;

    // rep_cnt_q stays below rep_limit, so the increment cannot overflow.
    assign rep_cnt_inc = rep_cnt_q + REP_W'(1);
    assign rep_limit   = rep_first_q ? REP_W'(REPEAT_DELAY_TICKS)
                                     : REP_W'(REPEAT_RATE_TICKS);
    assign rep_hit     = (rep_cnt_inc >= rep_limit);
`endif

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        fsm_d     = fsm_q;
        db_cnt_d  = db_cnt_q;
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
`endif

        case (fsm_q)
            IDLE: begin
                if (act) begin
                    fsm_d    = PRESS_DB;
                    db_cnt_d = '0;
                end
            end

            PRESS_DB: begin
                // Abort is checked before the tick so a change landing on
                // a tick cycle never counts.
                if (!act) begin
                    fsm_d    = IDLE;
                    db_cnt_d = '0;
                end else if (tick_i) begin
                    db_cnt_d = db_cnt_inc;
                    if (db_done) begin
                        fsm_d   = PRESSED;
                        state_d = 1'b1;
                        press_d = 1'b1;
`ifdef KEY_DEBOUNCE_REPEAT_EN
                        rep_cnt_d   = '0;
                        rep_first_d = 1'b1;
`endif
                    end
                end
            end

            PRESSED: begin
                if (!act) begin
                    fsm_d    = RELEASE_DB;
                    db_cnt_d = '0;
                end
`ifdef KEY_DEBOUNCE_REPEAT_EN
                else if (tick_i) begin
                    if (rep_hit) begin
                        press_d     = 1'b1;
                        rep_cnt_d   = '0;
                        rep_first_d = 1'b0;
                    end else begin
                        rep_cnt_d = rep_cnt_inc;
                    end
                end
`endif
            end

            RELEASE_DB: begin
                // A bounce back to pressed resumes PRESSED without touching
                // the repeat counter.
                if (act) begin
                    fsm_d    = PRESSED;
                    db_cnt_d = '0;
                end else if (tick_i) begin
                    db_cnt_d = db_cnt_inc;
                    if (db_done) begin
                        fsm_d     = IDLE;
                        state_d   = 1'b0;
                        release_d = 1'b1;
                    end
                end
            end

            default: begin
                fsm_d    = IDLE;
                db_cnt_d = '0;
                state_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            fsm_q     <= IDLE;
            db_cnt_q  <= '0;
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef KEY_DEBOUNCE_REPEAT_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    assign state_o     = state_q;
    assign state_nxt_o = state_d;
    assign press_o     = press_q;
    assign release_o   = release_q;

endmodule : key_debounce_ch
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : NUM_KEYS push-button debouncer. Holds the shared debounce
//               tick generator, one key_debounce_ch per key and the
//               registered key_any flag.
//               Optional feature macro: KEY_DEBOUNCE_REPEAT_EN (auto-repeat
//               key_press pulses while a key stays pressed).
// Ports       : sys_clk     - system clock
//               sys_rst     - asynchronous active-high reset
//               key_in      - raw button pins, asynchronous
//               key_state   - debounced level per key, 1 = pressed
//               key_press   - one-cycle pulse per accepted press / repeat
//               key_release - one-cycle pulse per accepted release
//               key_any     - OR of key_state
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS           = 4,
    parameter int KEY_ACTIVE_LOW     = 1,
    parameter int TICK_DIV           = TICK_DIV_1MS_50MHZ,
    parameter int DB_TICKS           = DB_TICKS_DEFAULT,
    parameter int REPEAT_DELAY_TICKS = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_RATE_TICKS  = REPEAT_RATE_DEFAULT
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                key_any
);

    if (TICK_DIV < 2) begin : g_chk_div
        $error("key_debounce: TICK_DIV must be >= 2");
    end

    // ------------------------------------------------------------------
    // Shared tick generator: counts 0..TICK_DIV-1, tick on the last value
    // ------------------------------------------------------------------
    localparam int TICK_W = cnt_width(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;

    assign tick       = (tick_cnt_q == c_tick_last);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-key channels
    // ------------------------------------------------------------------
    logic [NUM_KEYS-1:0] state_nxt;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce_ch #(
            .KEY_ACTIVE_LOW     (KEY_ACTIVE_LOW),
            .DB_TICKS           (DB_TICKS),
            .REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS),
            .REPEAT_RATE_TICKS  (REPEAT_RATE_TICKS)
        ) u_ch (
            .sys_clk     (sys_clk),
            .sys_rst     (sys_rst),
            .key_i       (key_in[k]),
            .tick_i      (tick),
            .state_o     (key_state[k]),
            .state_nxt_o (state_nxt[k]),
            .press_o     (key_press[k]),
            .release_o   (key_release[k])
        );
    end

    // key_any is registered from the channels' next levels so it changes in
    // the same cycle as key_state.
    logic key_any_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            key_any_q <= 1'b0;
        end else begin
            key_any_q <= |state_nxt;
        end
    end

    assign key_any = key_any_q;

endmodule : key_debounce
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_debounce
// Description : Self-checking bench for key_debounce (TICK_DIV=10,
//               DB_TICKS=4, NUM_KEYS=4, active-low pins, repeat 5/3 ticks).
//               A cycle-level behavioural model (run lengths and tick
//               counts per key) is compared against the DUT every cycle;
//               directed scenarios add hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce;

    localparam int NK = 4;
    localparam int TD = 10;
    localparam int DB = 4;
    localparam int RD = 5;
    localparam int RR = 3;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b0;
    logic [NK-1:0] key_in  = 4'hF;
    logic [NK-1:0] key_state;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          key_any;

    int checks = 0;
    int errors = 0;

    key_debounce #(
        .NUM_KEYS           (NK),
        .KEY_ACTIVE_LOW     (1),
        .TICK_DIV           (TD),
        .DB_TICKS           (DB),
        .REPEAT_DELAY_TICKS (RD),
        .REPEAT_RATE_TICKS  (RR)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .key_in      (key_in),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .key_any     (key_any)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Per key: run = consecutive cycles the synchronised
    // level has differed from the accepted level; ticks seen after the
    // first such cycle are counted and DB of them accept the change.
    // ------------------------------------------------------------------
    int            m_tcnt;
    logic [NK-1:0] m_s1, m_s2, m_acc, m_press, m_rel;
    int            m_run    [NK];
    int            m_ticks  [NK];
    int            m_rep    [NK];
    int            m_target [NK];

    always @(posedge sys_clk) begin : p_model
        logic [NK-1:0] act;
        logic          tick_now;
        if (sys_rst) begin
            m_tcnt  = 0;
            m_s1    = '1;
            m_s2    = '1;
            m_acc   = '0;
            m_press = '0;
            m_rel   = '0;
            for (int k = 0; k < NK; k++) begin
                m_run[k] = 0; m_ticks[k] = 0; m_rep[k] = 0; m_target[k] = RD;
            end
        end else begin
            tick_now = (m_tcnt == TD - 1);
            m_tcnt   = tick_now ? 0 : m_tcnt + 1;
            act      = ~m_s2;
            m_s2     = m_s1;
            m_s1     = key_in;
            m_press  = '0;
            m_rel    = '0;
            for (int k = 0; k < NK; k++) begin
`ifdef KEY_DEBOUNCE_REPEAT_EN
                // Sitting in the pressed state: accepted, previous cycle
                // agreed, and still pressed now.
                logic in_pressed;
                in_pressed = m_acc[k] && (m_run[k] == 0) && act[k];
`endif
                if (act[k] != m_acc[k]) begin
                    m_run[k]++;
                end else begin
                    m_run[k]   = 0;
                    m_ticks[k] = 0;
                end
                if (tick_now && m_run[k] >= 2) m_ticks[k]++;
                if (m_ticks[k] == DB) begin
                    m_acc[k]   = ~m_acc[k];
                    m_run[k]   = 0;
                    m_ticks[k] = 0;
                    if (m_acc[k]) begin
                        m_press[k]  = 1'b1;
                        m_rep[k]    = 0;
                        m_target[k] = RD;
                    end else begin
                        m_rel[k] = 1'b1;
                    end
                end
`ifdef KEY_DEBOUNCE_REPEAT_EN
                else if (in_pressed && tick_now) begin
                    m_rep[k]++;
                    if (m_rep[k] == m_target[k]) begin
                        m_press[k]  = 1'b1;
                        m_target[k] = m_target[k] + RR;
                    end
                end
`endif
            end
        end
        #1;
        check("model_cycle", {19'd0, key_state, key_press, key_release, key_any},
              {19'd0, m_acc, m_press, m_rel, |m_acc});
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    // Cycles from the first edge after an input change until the pulse is
    // visible (-1 on timeout).
    task automatic wait_pulse(input int bitn, input bit rel, output int lat);
        lat = -1;
        for (int c = 0; c < 60; c++) begin
            @(posedge sys_clk); #1;
            if (rel ? key_release[bitn] : key_press[bitn]) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic count_events(input int n, input int bitn, output int np, output int nr);
        np = 0;
        nr = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge sys_clk); #1;
            if (key_press[bitn])   np++;
            if (key_release[bitn]) nr++;
        end
    endtask

    initial begin : p_stim
        int lat, np, nr, cnt;

        // Reset
        #1 sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("reset_outputs", {25'd0, key_state, key_press, key_release, key_any}, 32'd0);
        sys_rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge sys_clk); #1;
            if ((|key_press) || (|key_release) || key_any) cnt++;
        end
        check("idle_quiet", cnt, 0);

        // Clean press / release of key 0
        @(negedge sys_clk); key_in[0] = 1'b0;
        wait_pulse(0, 1'b0, lat);
        check_range("press_latency", lat, 32, 42);
        check("press_state", {28'd0, key_state}, 32'h1);
        check("press_any", {31'd0, key_any}, 32'd1);
        @(posedge sys_clk); #1;
        check("press_single", {28'd0, key_press}, 32'h0);
        repeat (15) @(posedge sys_clk);
        @(negedge sys_clk); key_in[0] = 1'b1;
        wait_pulse(0, 1'b1, lat);
        check_range("release_latency", lat, 32, 42);
        check("release_state", {27'd0, key_state, key_any}, 32'd0);
        repeat (10) @(posedge sys_clk);

        // Bounce rejection on key 1
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge sys_clk);
            if (c % 7 == 0) key_in[1] = ~key_in[1];
            @(posedge sys_clk); #1;
            if (key_press[1] || key_release[1] || key_state[1]) cnt++;
        end
        @(negedge sys_clk); key_in[1] = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge sys_clk); #1;
            if (key_press[1] || key_release[1] || key_state[1]) cnt++;
        end
        check("bounce_rejected", cnt, 0);

        // Simultaneous keys 2 and 3
        @(negedge sys_clk); key_in[3:2] = 2'b00;
        for (int c = 0; c < 60; c++) begin
            @(posedge sys_clk); #1;
            if (key_press != '0) break;
        end
        check("simul_press", {28'd0, key_press}, 32'hC);
        check("simul_state", {28'd0, key_state}, 32'hC);
        @(negedge sys_clk); key_in = 4'hF;
        repeat (60) @(posedge sys_clk);

        // Reset during PRESS_DB, key still held afterwards
        @(negedge sys_clk); key_in[0] = 1'b0;
        repeat (20) @(posedge sys_clk);
        @(negedge sys_clk); sys_rst = 1'b1;
        #1 check("rst_db_state", {28'd0, key_state}, 32'h0);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        count_events(80, 0, np, nr);
        check("rst_db_fresh_press", np, 1);
        check("rst_db_no_release", nr, 0);

        // Reset while PRESSED, key let go during reset
        @(negedge sys_clk); sys_rst = 1'b1;
        #1 check("rst_pressed_state", {28'd0, key_state}, 32'h0);
        key_in[0] = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        count_events(60, 0, np, nr);
        check("rst_pressed_events", np + nr, 0);

        // Long hold: one pulse, or acceptance plus repeats at +50,+80,+110,+140
        @(negedge sys_clk); key_in[0] = 1'b0;
        count_events(200, 0, np, nr);
`ifdef KEY_DEBOUNCE_REPEAT_EN
        check("hold_press_count", np, 5);
`else
        check("hold_press_count", np, 1);
`endif
        @(negedge sys_clk); key_in = 4'hF;
        repeat (60) @(posedge sys_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_key_debounce
`default_nettype wire
